final2_soc_keycode_in: RTL
==========================

Name: final2_soc_keycode_in

Overview:
- Avalon-MM slave input port that collects keycodes produced by fabric logic and lets the Nios II CPU read them.
- Companion to the CPU-written keycode output port; data flows hardware → CPU.
- Each keycode arriving with a valid strobe is buffered in a small FIFO. The CPU pops it by reading the DATA register.
- Status, interrupt mask and flush control share the same 2-bit address window.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DATA_W, 32, keycode width; bits above DATA_W read as 0.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  2  register select
- chipselect  input  1  slave select
- read_n  input  1  active-low read strobe
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  registered read data, read latency 1
- in_port  input  DATA_W  keycode from fabric (same clk domain)
- in_valid  input  1  one-cycle push strobe
- irq  output  1  level interrupt to CPU

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low on reset_n. On reset the FIFO is empty (pointers and count = 0), overflow = 0, irqmask = 0, readdata = 0, irq = 0.
- Strobes:
  - rd = chipselect & ~read_n.
  - wr = chipselect & ~write_n.
  - Each strobe is asserted for exactly one cycle per transfer (fixed 0 wait states, no waitrequest).
- Readdata timing: readdata is updated on the clock edge after rd. It samples register state before that edge's updates. It holds its value when rd = 0.
- Register map:
  - addr 0 DATA:
    - Read returns the head entry, zero-extended; returns 0 if empty.
    - Read pops one entry if not empty. Read when empty has no side effect.
    - Writes are ignored.
  - addr 1 STATUS:
    - Read fields: [7:0] count, [8] empty, [9] full, [10] overflow (sticky), other bits 0.
    - Write with writedata[10] = 1 clears overflow (W1C).
  - addr 2 IRQMASK:
    - R/W bits [1:0]: bit0 = not-empty interrupt enable, bit1 = overflow interrupt enable.
    - Other bits read 0.
  - addr 3 CONTROL:
    - Write with writedata[0] = 1 flushes the FIFO (pointers and count = 0; overflow unchanged).
    - Reads 0.
- Push:
  - in_valid = 1 and FIFO not full → store in_port at the tail; count + 1.
  - in_valid = 1 and full with no same-cycle pop → keycode dropped, overflow set to 1.
- Simultaneous events:
  - Push and pop in the same cycle while full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the pop is ignored (readdata 0), the push is accepted, count = 1.
  - Push and pop otherwise: count unchanged, head advances, tail advances.
  - Flush in the same cycle as a push: flush wins, push discarded, overflow not set.
  - Overflow set and W1C clear in the same cycle: set wins.
- Pointers: wrap modulo DEPTH. Count ranges 0..DEPTH; full = (count == DEPTH).
- irq:
  - irq = (irqmask[0] & ~empty) | (irqmask[1] & overflow).
  - Registered: updates one cycle after the causing event.
- Reset mid-transfer: aborts immediately; no pop is committed.

Decomposition:
- Shared package (final2_soc_pio_pkg):
  - Register address constants ADDR_DATA = 0, ADDR_STATUS = 1, ADDR_IRQMASK = 2, ADDR_CONTROL = 3.
  - STATUS bit indices (EMPTY_BIT = 8, FULL_BIT = 9, OVF_BIT = 10).
- One natural sub-module: final2_soc_sync_fifo, parameterised on DEPTH and DATA_W.
  - Interface: push, pop, flush, dout, count, empty, full.
  - Both push and pop are accepted when full.
- The top level holds the Avalon decode, overflow, irqmask, readdata and irq registers.

Test Plan:
- Reset, then read STATUS → readdata = 0x100 (count 0, empty); read DATA → 0; irq = 0.
- Push 0x1A then 0x2B; read DATA twice → 0x1A, then 0x2B; STATUS → 0x100.
- DEPTH = 8: push 9 keycodes 0x01..0x09 → STATUS = 0x608 (count 8, full, overflow); DATA reads return 0x01..0x08. Write STATUS 0x400 → overflow = 0.
- Fill to 8 entries, then in the same cycle push 0x55 and read DATA → returns head 0x01; count stays 8; overflow stays 0; 0x55 is the last entry popped.
- Write IRQMASK = 1, push 0x33 → irq = 1 one cycle later. Pop → irq = 0. Write IRQMASK = 2, overflow the FIFO → irq = 1 until W1C.
- Push 3 entries, write CONTROL = 1 in the same cycle as a push → STATUS = 0x100, overflow = 0. Assert reset_n = 0 mid-read → readdata = 0 and irq = 0 asynchronously.

Source files
------------

// File: rtl/final2_soc_pio_pkg.sv
// Shared register map for the keycode PIO ports: Avalon word addresses
// and STATUS field positions.
package final2_soc_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    localparam int EMPTY_BIT = 8;
    localparam int FULL_BIT  = 9;
    localparam int OVF_BIT   = 10;

endpackage

// File: rtl/final2_soc_sync_fifo.sv
// Single-clock FIFO with count. A push is accepted while full when a pop
// happens in the same cycle; flush overrides both push and pop.
module final2_soc_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]       count_reg, count_next;
    logic              push_ok, pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign push_ok = push & ~flush & (~full | pop);
    assign pop_ok  = pop & ~flush & ~empty;
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    // Storage needs no reset: an entry is only visible after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/final2_soc_keycode_in.sv
// Avalon-MM slave that buffers fabric keycodes in a FIFO for the CPU,
// with STATUS, IRQMASK and CONTROL registers and a level interrupt.
module final2_soc_keycode_in
    import final2_soc_pio_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_valid,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              rd, wr, pop, flush, ovf_set, ovf_clr;
    logic [DATA_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty, fifo_full;
    logic [31:0]       rd_mux;
    logic              overflow_reg, irq_reg;
    logic [1:0]        irqmask_reg;
    logic [31:0]       readdata_reg;
    logic              unused_wdata;

    assign rd      = chipselect & ~read_n;
    assign wr      = chipselect & ~write_n;
    assign pop     = rd & (address == ADDR_DATA);
    assign flush   = wr & (address == ADDR_CONTROL) & writedata[0];
    // A full FIFO is never empty, so a DATA read always frees a slot here.
    assign ovf_set = in_valid & fifo_full & ~pop & ~flush;
    assign ovf_clr = wr & (address == ADDR_STATUS) & writedata[OVF_BIT];
    assign unused_wdata = ^{writedata[31:OVF_BIT+1], writedata[OVF_BIT-1:2]};

    final2_soc_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid),
        .pop     (pop),
        .flush   (flush),
        .din     (in_port),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: begin
                if (!fifo_empty) rd_mux = 32'(fifo_dout);
            end
            ADDR_STATUS: begin
                rd_mux[7:0]       = 8'(fifo_count);
                rd_mux[EMPTY_BIT] = fifo_empty;
                rd_mux[FULL_BIT]  = fifo_full;
                rd_mux[OVF_BIT]   = overflow_reg;
            end
            ADDR_IRQMASK: rd_mux[1:0] = irqmask_reg;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= '0;
            overflow_reg <= 1'b0;
            irqmask_reg  <= 2'b00;
            irq_reg      <= 1'b0;
        end else begin
            if (rd) readdata_reg <= rd_mux;
            if (ovf_set)      overflow_reg <= 1'b1;
            else if (ovf_clr) overflow_reg <= 1'b0;
            if (wr && address == ADDR_IRQMASK) irqmask_reg <= writedata[1:0];
            irq_reg <= (irqmask_reg[0] & ~fifo_empty) | (irqmask_reg[1] & overflow_reg);
        end
    end

    assign readdata = readdata_reg;
    assign irq      = irq_reg;

endmodule
